teatris_varredura_matriz: RTL and testbench
===========================================

TEATRIS_VARREDURA_MATRIZ -- requirements
Module: teatris_varredura_matriz

Interface
REQ-001 SHALL have parameter DIV_LINHA, default 50000: clock cycles per row slot (1 kHz row rate at 50 MHz).
REQ-002 SHALL have parameter BLANK, default 16: blanking cycles at the start of each row slot; legal range 1 <= BLANK <= DIV_LINHA-2.
REQ-003 SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port padrao  input  64  8x8 map from the map ROMs; bits [63:56] are row 0 (top); bit 7 of each byte is the leftmost column.
REQ-006 SHALL have port padrao_valido  input  1  one-cycle strobe; padrao is captured when it is high.
REQ-007 SHALL have port linhas  output  8  row select, one-hot, active-low; 8'hFF means no row driven.
REQ-008 SHALL have port colunas  output  8  column data, active-high.
REQ-009 SHALL have port quadro_fim  output  1  one-cycle pulse on the last cycle of row 7.

Function
REQ-010 SHALL hold two 64-bit registers: pendente (written by padrao_valido) and ativo (displayed), plus a flag pendente_cheio.
REQ-011 SHALL, on padrao_valido, copy padrao into pendente and set pendente_cheio; a later strobe before the frame boundary overwrites it (last wins).
REQ-012 SHALL scan rows 0..7 cyclically, each row for exactly DIV_LINHA cycles, using slot counter c (0..DIV_LINHA-1) and row index k (0..7, wraps 7->0).
REQ-013 SHALL run a two-state FSM per slot: APAGADO for c < BLANK (linhas=8'hFF, colunas=0), then ACESO for c >= BLANK (linhas=~(1<<k), colunas=ativo[63-8k -: 8]).
REQ-014 SHALL register all outputs; outputs for counter value c are valid in the same cycle that c is held.
REQ-015 SHALL assert quadro_fim only when k=7 and c=DIV_LINHA-1.
REQ-016 SHALL, on the edge ending that quadro_fim cycle, transfer pendente to ativo and clear pendente_cheio if pendente_cheio=1; otherwise ativo is unchanged.
REQ-017 SHALL, when padrao_valido coincides with the quadro_fim cycle, transfer the new padrao directly to ativo (bypass) and leave pendente_cheio=0.
REQ-018 SHALL never change ativo mid-frame, so no tearing is visible.
REQ-019 SHALL never drive more than one row low in the same cycle.

Reset
REQ-020 SHALL, while reset_n=0, force linhas=8'hFF, colunas=0, quadro_fim=0, c=0, k=0, ativo=0, pendente=0, pendente_cheio=0.
REQ-021 SHALL, after reset_n deasserts, start in APAGADO of row 0 on the first rising edge; a reset mid-frame discards both buffers.

Configuration
REQ-022 SHALL, with macro TEATRIS_BRILHO_EN defined, add input brilho[2:0]; in ACESO, colunas is forced to 0 unless (c-BLANK) < ((brilho+1)*(DIV_LINHA-BLANK))/8, with brilho=7 giving full on-time.
REQ-023 SHALL sample brilho only at the frame boundary (REQ-016 edge); after reset the sampled brilho is 7.
REQ-024 SHALL, without TEATRIS_BRILHO_EN, omit the brilho port, and ACESO drives colunas for all DIV_LINHA-BLANK cycles.

Structure
REQ-025 SHALL take LINHAS=8, COLUNAS=8 and QUADRO_W=64 from shared package teatris_pkg, which is also used by the map ROMs.
REQ-026 SHALL instantiate one sub-module, teatris_divisor, holding c and producing the slot tick and c value; row logic, FSM and buffers stay in the top.

Verification (DIV_LINHA=10, BLANK=2)
REQ-027 SHALL cover: reset_n low mid-scan -> linhas=8'hFF, colunas=0 immediately without a clock edge, and row 0 in APAGADO after release.
REQ-028 SHALL cover: padrao=64'h08_1C_FE_0F_FF_0F_BF_0F strobed, then one full frame -> after the boundary, row 0 shows colunas=8'h08 for c=2..9 and row 2 shows 8'hFE, with linhas=8'hFE then 8'hFB.
REQ-029 SHALL cover: two strobes (A then B) within one frame -> only B is displayed after the boundary; A never appears.
REQ-030 SHALL cover: strobe in the quadro_fim cycle -> the new pattern is displayed from the next row 0, and pendente_cheio=0.
REQ-031 SHALL cover: continuous run for 3 frames -> quadro_fim pulses every 80 cycles, and at most one linhas bit is low in every cycle.
REQ-032 SHALL cover: with TEATRIS_BRILHO_EN and brilho=3 -> colunas nonzero for exactly 4 cycles per row slot (c=2..5).

Source files
------------

// File: rtl/teatris_pkg.sv
// -----------------------------------------------------------------------------
// teatris_pkg
// Shared definitions for the Teatris 8x8 matrix: geometry constants, the frame
// type used by the scanner and the map ROMs, the scan FSM states and a helper
// that builds the active-low row select.
// -----------------------------------------------------------------------------
package teatris_pkg;

    localparam int LINHAS   = 8;
    localparam int COLUNAS  = 8;
    localparam int QUADRO_W = LINHAS * COLUNAS;
    localparam int K_W      = $clog2(LINHAS);

    // Row 0 (top) lives in bits [63:56], i.e. outer index LINHAS-1.
    typedef logic [LINHAS-1:0][COLUNAS-1:0] quadro_t;

    typedef enum logic {
        APAGADO = 1'b0,
        ACESO   = 1'b1
    } estado_t;

    // One-hot, active-low row select for row k.
    function automatic logic [LINHAS-1:0] seleciona_linha(input logic [K_W-1:0] k);
        return ~(LINHAS'(1) << k);
    endfunction

endpackage

// File: rtl/teatris_varredura_matriz_if.sv
// -----------------------------------------------------------------------------
// teatris_varredura_matriz_if
// Pattern input and matrix drive signals of the scanner.
//   padrao        : 8x8 map, row 0 in [63:56], bit 7 of a byte = leftmost column
//   padrao_valido : one-cycle strobe capturing padrao
//   brilho        : brightness 0..7 (only with TEATRIS_BRILHO_EN defined)
//   linhas        : one-hot active-low row select, 8'hFF = no row
//   colunas       : active-high column data
//   quadro_fim    : one-cycle pulse on the last cycle of row 7
// master = pattern source side, slave = scanner side.
// -----------------------------------------------------------------------------
interface teatris_varredura_matriz_if;
    import teatris_pkg::*;

    logic [QUADRO_W-1:0] padrao;
    logic                padrao_valido;
`ifdef TEATRIS_BRILHO_EN
    logic [2:0]          brilho;
`endif
    logic [LINHAS-1:0]   linhas;
    logic [COLUNAS-1:0]  colunas;
    logic                quadro_fim;

    modport master (
        output padrao, padrao_valido,
`ifdef TEATRIS_BRILHO_EN
        output brilho,
`endif
        input  linhas, colunas, quadro_fim
    );

    modport slave (
        input  padrao, padrao_valido,
`ifdef TEATRIS_BRILHO_EN
        input  brilho,
`endif
        output linhas, colunas, quadro_fim
    );

endinterface

// File: rtl/teatris_divisor.sv
// -----------------------------------------------------------------------------
// teatris_divisor
// Row slot counter c, counting 0..DIV_LINHA-1 and wrapping.
//   clock, reset_n : clock and asynchronous active-low reset (c = 0)
//   c_prox         : value c takes after the next rising edge
//   fim_slot       : high while c = DIV_LINHA-1 (last cycle of a row slot)
// -----------------------------------------------------------------------------
module teatris_divisor #(
    parameter int DIV_LINHA = 50000,
    parameter int C_W       = $clog2(DIV_LINHA)
) (
    input  logic           clock,
    input  logic           reset_n,
    output logic [C_W-1:0] c_prox,
    output logic           fim_slot
);

    logic [C_W-1:0] c;

    assign fim_slot = (c == C_W'(DIV_LINHA - 1));
    assign c_prox   = fim_slot ? '0 : c + C_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) c <= '0;
        else          c <= c_prox;
    end

endmodule

// File: rtl/teatris_varredura_matriz.sv
// -----------------------------------------------------------------------------
// teatris_varredura_matriz
// Row-scanning driver for an 8x8 LED matrix with a double-buffered pattern.
// A strobed pattern waits in pendente and is promoted to ativo only at the
// frame boundary, so a frame is never torn.
//   clock, reset_n : clock and asynchronous active-low reset
//   bus (slave)    : padrao/padrao_valido in, linhas/colunas/quadro_fim out
// Parameters: DIV_LINHA cycles per row slot, BLANK blanking cycles per slot
// (1 <= BLANK <= DIV_LINHA-2).
// Optional: define TEATRIS_BRILHO_EN to add bus.brilho, which shortens the
// lit part of each slot; it is sampled at frame boundaries, 7 after reset.
// -----------------------------------------------------------------------------
module teatris_varredura_matriz
    import teatris_pkg::*;
#(
    parameter int DIV_LINHA = 50000,
    parameter int BLANK     = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    teatris_varredura_matriz_if.slave    bus
);

    localparam int C_W = $clog2(DIV_LINHA);

    logic [C_W-1:0]     c_prox;
    logic               fim_slot;
    logic [K_W-1:0]     k, k_prox;
    logic               quadro_agora;

    quadro_t            ativo, ativo_prox;
    quadro_t            pendente, pendente_prox;
    logic               cheio, cheio_prox;

    estado_t            estado, estado_prox;
    logic [LINHAS-1:0]  linhas_q, linhas_prox;
    logic [COLUNAS-1:0] colunas_q, colunas_prox;
    logic               quadro_q, quadro_prox;

    teatris_divisor #(.DIV_LINHA(DIV_LINHA), .C_W(C_W)) u_divisor (
        .clock    (clock),
        .reset_n  (reset_n),
        .c_prox   (c_prox),
        .fim_slot (fim_slot)
    );

    assign k_prox       = fim_slot ? k + K_W'(1) : k;
    assign quadro_agora = fim_slot && (k == K_W'(LINHAS - 1));

    // Buffer update: a strobe outside the boundary lands in pendente (last
    // wins); at the boundary a coinciding strobe bypasses straight to ativo,
    // otherwise a full pendente is promoted.
    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        ativo_prox    = ativo;
        pendente_prox = pendente;
        cheio_prox    = cheio;
        if (quadro_agora) begin
            if (bus.padrao_valido) begin
                ativo_prox = bus.padrao;
                cheio_prox = 1'b0;
            end else if (cheio) begin
                ativo_prox = pendente;
                cheio_prox = 1'b0;
            end
        end else if (bus.padrao_valido) begin
            pendente_prox = bus.padrao;
            cheio_prox    = 1'b1;
        end
    end

`ifdef TEATRIS_BRILHO_EN
    logic [2:0] brilho_amostrado;
    int         limite;
`endif

    // Outputs are registered, so they are computed from the values the slot
    // counter, row index and ativo hold after the coming edge.
    always_comb begin
        estado_prox  = estado;
        linhas_prox  = '1;
        colunas_prox = '0;
        quadro_prox  = (k_prox == K_W'(LINHAS - 1)) && (c_prox == C_W'(DIV_LINHA - 1));
`ifdef TEATRIS_BRILHO_EN
        limite = ((int'(brilho_amostrado) + 1) * (DIV_LINHA - BLANK)) / 8;
`endif
        case (estado)
            APAGADO: if (c_prox == C_W'(BLANK)) estado_prox = ACESO;
            ACESO:   if (fim_slot)              estado_prox = APAGADO;
            default:                            estado_prox = APAGADO;
        endcase
        if (estado_prox == ACESO) begin
            linhas_prox  = seleciona_linha(k_prox);
            colunas_prox = ativo_prox[K_W'(LINHAS - 1) - k_prox];
`ifdef TEATRIS_BRILHO_EN
            if (int'(c_prox) - BLANK >= limite) colunas_prox = '0;
`endif
        end
    end

    // NOTE: the 64-bit buffers are reset too, because a reset must blank the
    // display and discard any pattern in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            k         <= '0;
            ativo     <= '0;
            pendente  <= '0;
            cheio     <= 1'b0;
            estado    <= APAGADO;
            linhas_q  <= '1;
            colunas_q <= '0;
            quadro_q  <= 1'b0;
        end else begin
            k         <= k_prox;
            ativo     <= ativo_prox;
            pendente  <= pendente_prox;
            cheio     <= cheio_prox;
            estado    <= estado_prox;
            linhas_q  <= linhas_prox;
            colunas_q <= colunas_prox;
            quadro_q  <= quadro_prox;
        end
    end

`ifdef TEATRIS_BRILHO_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)          brilho_amostrado <= 3'd7;
        else if (quadro_agora) brilho_amostrado <= bus.brilho;
    end
`endif

    assign bus.linhas     = linhas_q;
    assign bus.colunas    = colunas_q;
    assign bus.quadro_fim = quadro_q;

endmodule

// File: tb/tb_teatris_varredura_matriz.sv
// -----------------------------------------------------------------------------
// tb_teatris_varredura_matriz
// Scoreboard bench for teatris_varredura_matriz with DIV_LINHA=10, BLANK=2.
// The driver keeps a small model of the displayed frame and, at each frame
// boundary, queues the expected {linhas, colunas} for every lit cycle of the
// next frame. The monitor pops one entry per lit cycle and also checks the
// single-row rule, dark columns while blanked and the quadro_fim period.
// -----------------------------------------------------------------------------
module tb_teatris_varredura_matriz;
    import teatris_pkg::*;

    localparam int DIV = 10;
    localparam int BLK = 2;

    localparam logic [63:0] PAD_P1 = 64'h081C_FE0F_FF0F_BF0F;
    localparam logic [63:0] PAD_A  = 64'h0102_0408_1020_4080;
    localparam logic [63:0] PAD_B  = 64'hF0E0_C0A0_9088_7F3C;
    localparam logic [63:0] PAD_C  = 64'h3C42_8181_8181_423C;

    typedef struct packed {
        logic [7:0] linhas;
        logic [7:0] colunas;
    } saida_t;

    logic clock = 1'b0;
    logic reset_n;

    teatris_varredura_matriz_if bus();

    teatris_varredura_matriz #(.DIV_LINHA(DIV), .BLANK(BLK)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    saida_t      fila[$];
    int          testes = 0;
    int          falhas = 0;
    bit          armado = 1'b0;

    logic [63:0] ativo_m, pend_m;
    bit          cheio_m;
    int          bri_m;
`ifdef TEATRIS_BRILHO_EN
    int          bri_in = 3;
`else
    int          bri_in = 7;
`endif

    task automatic check(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
        testes++;
        if (atual !== esperado) begin
            falhas++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    function automatic logic [7:0] coluna_esperada(input logic [63:0] q, input int k, input int c, input int bri);
        int lim;
        lim = ((bri + 1) * (DIV - BLK)) / 8;
        if (c - BLK >= lim) return 8'h00;
        return q[63 - 8*k -: 8];
    endfunction

    task automatic empilha_quadro(input logic [63:0] q, input int bri);
        saida_t s;
        for (int k = 0; k < 8; k++) begin
            for (int c = BLK; c < DIV; c++) begin
                s.linhas  = ~(8'h01 << k);
                s.colunas = coluna_esperada(q, k, c, bri);
                fila.push_back(s);
            end
        end
    endtask

    task automatic strobe(input logic [63:0] p);
        bus.padrao        = p;
        bus.padrao_valido = 1'b1;
        @(negedge clock);
        bus.padrao_valido = 1'b0;
        pend_m  = p;
        cheio_m = 1'b1;
    endtask

    task automatic espera_quadro(input int limite, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limite; i++) begin
            @(negedge clock);
            if (bus.quadro_fim === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            testes++;
            falhas++;
            $display("FAIL espera_quadro: quadro_fim not seen within %0d cycles", limite);
        end
    endtask

    // Called at the falling edge inside the quadro_fim cycle.
    task automatic fronteira(input bit bypass, input logic [63:0] p);
        if (bypass) begin
            bus.padrao        = p;
            bus.padrao_valido = 1'b1;
            ativo_m = p;
            cheio_m = 1'b0;
        end else if (cheio_m) begin
            ativo_m = pend_m;
            cheio_m = 1'b0;
        end
        bri_m = bri_in;
        empilha_quadro(ativo_m, bri_m);
        @(negedge clock);
        bus.padrao_valido = 1'b0;
    endtask

    task automatic modelo_reset();
        ativo_m = '0;
        pend_m  = '0;
        cheio_m = 1'b0;
        bri_m   = 7;
        empilha_quadro(ativo_m, bri_m);
    endtask

    // Monitor: compares every lit cycle against the scoreboard.
    int ciclos = 0;
    bit visto  = 1'b0;
    always @(negedge clock) begin
        saida_t s;
        if (armado) begin
            if (!reset_n) begin
                visto = 1'b0;
            end else begin
                ciclos++;
                check("linha_unica", 64'($countones(~bus.linhas) <= 1), 64'd1);
                if (bus.linhas == 8'hFF) begin
                    check("apagado_colunas", 64'(bus.colunas), 64'h0);
                end else if (fila.size() == 0) begin
                    testes++;
                    falhas++;
                    $display("FAIL fila_vazia: lit output %h/%h with nothing expected", bus.linhas, bus.colunas);
                end else begin
                    s = fila.pop_front();
                    check("saida_linha", 64'({bus.linhas, bus.colunas}), 64'(s));
                end
                if (bus.quadro_fim === 1'b1) begin
                    check("quadro_linha7", 64'(bus.linhas), 64'h7F);
                    if (visto) check("periodo_quadro", 64'(ciclos), 64'd80);
                    visto  = 1'b1;
                    ciclos = 0;
                end
            end
        end
    end

    initial begin
        bit ok;
        bus.padrao        = '0;
        bus.padrao_valido = 1'b0;
`ifdef TEATRIS_BRILHO_EN
        bus.brilho        = 3'd3;
`endif
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        modelo_reset();
        armado = 1'b1;
        check("reset_saidas", 64'({bus.linhas, bus.colunas, 7'd0, bus.quadro_fim}), 64'hFF00_00);
        @(negedge clock);
        check("linha0_apagado", 64'(bus.linhas), 64'hFF);

        // Frame 0: blank display, P1 queued.
        repeat (10) @(negedge clock);
        strobe(PAD_P1);
        espera_quadro(100, ok);
        fronteira(1'b0, '0);

        // Frame 1: P1 shown; A then B queued, B must win.
        repeat (5) @(negedge clock);
        strobe(PAD_A);
        repeat (20) @(negedge clock);
        strobe(PAD_B);
        espera_quadro(100, ok);
        fronteira(1'b0, '0);

        // Frame 2: B shown; A queued, then C strobed in the quadro_fim cycle.
        repeat (10) @(negedge clock);
        strobe(PAD_A);
        espera_quadro(100, ok);
        fronteira(1'b1, PAD_C);

        // Frame 3: C shown; pendente must be empty, so C stays.
        espera_quadro(100, ok);
        fronteira(1'b0, '0);

        // Frame 4: reset in the lit part of row 2.
        repeat (29) @(negedge clock);
        check("antes_reset_linha2", 64'(bus.linhas), 64'hFB);
        reset_n = 1'b0;
        #1;
        check("reset_async_linhas", 64'(bus.linhas), 64'hFF);
        check("reset_async_colunas", 64'(bus.colunas), 64'h00);
        check("reset_async_quadro", 64'(bus.quadro_fim), 64'h0);
        fila.delete();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        modelo_reset();
        check("reset2_linhas", 64'(bus.linhas), 64'hFF);
        @(negedge clock);
        check("reset2_linha0_apagado", 64'(bus.linhas), 64'hFF);

        // One blank frame after the mid-scan reset, then stop.
        espera_quadro(100, ok);
        @(negedge clock);
        check("fila_consumida", 64'(fila.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule
